muldiv_hilo: RTL

- Execute-side multi-cycle arithmetic unit for St.PU.
- Consumes MULT, MULTU, DIV, DIVU, MTHI and MTLO operations issued by the decode stage and forwarded by the EX stage.
- Owns the architectural HI/LO registers and runs a 32-iteration radix-2 divider.
- Raises a stall request that freezes the front of the pipeline while an operation is in flight.

---
 rtl/muldiv_hilo_if.sv | 23 ++
 rtl/muldiv_hilo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_if.sv
// EX-stage <-> HI/LO multiply/divide unit bus: op issue, flush, HI/LO and status back.
interface muldiv_hilo_if;
  logic        start_i;
  logic [7:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;
  logic        done_o;
  logic        divzero_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, annul_i,
    input  hi_o, lo_o, stallreq_o, done_o, divzero_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
    output hi_o, lo_o, stallreq_o, done_o, divzero_o
  );
endinterface

// File: rtl/muldiv_hilo.sv
// HI/LO owner with 32-step radix-2 restoring divider. Define MULDIV_ITER_MULT_EN to run
// MULT/MULTU through the same iterative engine instead of a single-cycle multiplier.
module muldiv_hilo (
  input  logic         clk,
  input  logic         rst,
  muldiv_hilo_if.slave bus
);
  localparam logic [7:0] OpMthi  = 8'b0001_0001;
  localparam logic [7:0] OpMtlo  = 8'b0001_0011;
  localparam logic [7:0] OpMult  = 8'b0001_1000;
  localparam logic [7:0] OpMultu = 8'b0001_1001;
  localparam logic [7:0] OpDiv   = 8'b0001_1010;
  localparam logic [7:0] OpDivu  = 8'b0001_1011;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  state_e state_q, state_d;

  logic [5:0]  cnt_q;
  logic [31:0] opa_q, opb_q, hi_q, lo_q;
  logic [63:0] acc_q;
  logic        neg_q, rneg_q, is_div_q, dz_q, done_q, divzero_q;

  logic        is_div, is_mul, is_signed, multi, dz;
  logic [31:0] mag_a, mag_b;
  logic [64:0] div_sh;
  logic [32:0] div_sub;
  logic [63:0] div_step, step;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    is_div    = (bus.op_i == OpDiv) || (bus.op_i == OpDivu);
    is_mul    = (bus.op_i == OpMult) || (bus.op_i == OpMultu);
    is_signed = (bus.op_i == OpDiv) || (bus.op_i == OpMult);
`ifdef MULDIV_ITER_MULT_EN
    multi     = is_div || is_mul;
`else
    multi     = is_div;
`endif
    dz        = is_div && (bus.opdata2_i == 32'd0);
    mag_a     = (is_signed && bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
    mag_b     = (is_signed && bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;
  end

  // Restoring divide step on {rem, quo}; rem needs 33 bits after the shift.
  always_comb begin
    div_sh  = {acc_q, 1'b0};
    div_sub = div_sh[64:32] - {1'b0, opb_q};
    if (div_sh[64:32] >= {1'b0, opb_q}) begin
      div_step = {div_sub[31:0], div_sh[31:1], 1'b1};
    end else begin
      div_step = div_sh[63:0];
    end
  end

`ifdef MULDIV_ITER_MULT_EN
  logic [32:0] mul_sum;
  // Shift-add: accumulate into the upper half, multiplier bits consumed from the LSB.
  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
    step    = is_div_q ? div_step : {mul_sum, acc_q[31:1]};
  end
`else
  logic [63:0] prod;
  always_comb begin
    step = div_step;
    prod = {{32{is_signed & bus.opdata1_i[31]}}, bus.opdata1_i}
         * {{32{is_signed & bus.opdata2_i[31]}}, bus.opdata2_i};
  end
`endif

  always_comb begin
    if (dz_q) begin
      res_lo = 32'hFFFF_FFFF;
      res_hi = rneg_q ? -opa_q : opa_q;
    end else if (is_div_q) begin
      res_lo = neg_q ? -acc_q[31:0] : acc_q[31:0];
      res_hi = rneg_q ? -acc_q[63:32] : acc_q[63:32];
    end else begin
      {res_hi, res_lo} = neg_q ? -acc_q : acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.annul_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (bus.start_i && multi) state_d = dz ? StDone : StBusy;
        StBusy:  if (cnt_q == 6'd31) state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.stallreq_o = !bus.annul_i &&
                     ((state_q == StBusy) || (state_q == StIdle && bus.start_i && multi));
    bus.hi_o       = hi_q;
    bus.lo_o       = lo_q;
    bus.done_o     = done_q;
    bus.divzero_o  = divzero_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 6'd0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      if (!bus.annul_i) begin
        unique case (state_q)
          StIdle: begin
            if (bus.start_i && multi) begin
              opa_q     <= mag_a;
              opb_q     <= mag_b;
              acc_q     <= {32'd0, is_div ? mag_a : mag_b};
              neg_q     <= is_signed && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
              rneg_q    <= is_signed && bus.opdata1_i[31];
              is_div_q  <= is_div;
              dz_q      <= dz;
              cnt_q     <= 6'd0;
              done_q    <= dz;
              divzero_q <= dz;
            end else if (bus.start_i && bus.op_i == OpMthi) begin
              hi_q <= bus.opdata1_i;
            end else if (bus.start_i && bus.op_i == OpMtlo) begin
              lo_q <= bus.opdata1_i;
`ifndef MULDIV_ITER_MULT_EN
            end else if (bus.start_i && is_mul) begin
              {hi_q, lo_q} <= prod;
`endif
            end
          end
          StBusy: begin
            cnt_q  <= cnt_q + 6'd1;
            acc_q  <= step;
            done_q <= (cnt_q == 6'd31);
          end
          StDone: begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
